// File: rtl/elevator_req_ctrl.sv
// elevator_req_ctrl: request latching and car/door controller for a two-floor
// elevator. It latches hall and car calls, runs the IDLE/DOOR/MOVE state
// machine from a shared down-counter, and drives registered floor, motion,
// door and request-lamp outputs.
//
// Optional feature: define DOOR_HOLD_EN to add the door_hold input, which
// freezes the door timer while the door is open.

module elevator_req_ctrl #(
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000,
  parameter int TIMER_W       = 27
) (
  input  logic       clk,
  input  logic       rst,
`ifdef DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  input  logic       up,
  input  logic       down,
  input  logic       to_one,
  input  logic       to_two,
  output logic       floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic [3:0] req,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DOOR    = 2'd1,
    MOVE_UP = 2'd2,
    MOVE_DN = 2'd3
  } state_t;

  // Request bit order is {to_two, to_one, down, up}.
  localparam logic [3:0] FLOOR1_MASK = 4'b0101;
  localparam logic [3:0] FLOOR2_MASK = 4'b1010;

  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

  state_t             cur_st, nxt_st;
  logic               cur_floor, nxt_floor;
  logic [TIMER_W-1:0] timer, nxt_timer;
  logic [3:0]         req_q, nxt_req;

  logic [3:0] pulse;
  logic [3:0] here_mask, there_mask;
  logic       demand_here, demand_there, pulse_here;
  logic       timer_done;
  logic       hold;

  assign pulse        = {to_two, to_one, down, up};
  assign here_mask    = cur_floor ? FLOOR2_MASK : FLOOR1_MASK;
  assign there_mask   = cur_floor ? FLOOR1_MASK : FLOOR2_MASK;
  assign demand_here  = |(req_q & here_mask);
  assign demand_there = |(req_q & there_mask);
  assign pulse_here   = |(pulse & here_mask);
  assign timer_done   = (timer == '0);

`ifdef DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  // Next-state, next-floor and timer decisions for the car/door FSM.
  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    nxt_st    = cur_st;
    nxt_floor = cur_floor;
    nxt_timer = timer;
    unique case (cur_st)
      IDLE: begin
        if (demand_here) begin
          nxt_st    = DOOR;
          nxt_timer = DOOR_LOAD;
        end else if (demand_there) begin
          nxt_st    = cur_floor ? MOVE_DN : MOVE_UP;
          nxt_timer = TRAVEL_LOAD;
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (timer_done) begin
          nxt_st    = DOOR;
          nxt_floor = ~cur_floor;
          nxt_timer = DOOR_LOAD;
        end else begin
          nxt_timer = timer - TIMER_ONE;
        end
      end
      DOOR: begin
        if (pulse_here) begin
          // A fresh call for this floor re-opens the door.
          nxt_timer = DOOR_LOAD;
        end else if (hold) begin
          nxt_timer = timer;
        end else if (timer_done) begin
          nxt_st = IDLE;
        end else begin
          nxt_timer = timer - TIMER_ONE;
        end
      end
      default: begin
        nxt_st = IDLE;
      end
    endcase
  end

  // Latch new calls; calls for the floor being served this edge are dropped.
  always_comb begin
    nxt_req = req_q | pulse;
    if (nxt_st == DOOR) begin
      nxt_req = nxt_req & ~(nxt_floor ? FLOOR2_MASK : FLOOR1_MASK);
    end
  end

  // FSM, floor, timer and request registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      cur_st    <= IDLE;
      cur_floor <= 1'b0;
      timer     <= '0;
      req_q     <= '0;
    end else begin
      cur_st    <= nxt_st;
      cur_floor <= nxt_floor;
      timer     <= nxt_timer;
      req_q     <= nxt_req;
    end
  end

  // Registered display outputs decoded from the current state and floor.
  always_ff @(posedge clk) begin
    if (rst) begin
      floor       <= 1'b0;
      state       <= 2'd0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
    end else begin
      floor       <= cur_floor;
      state       <= cur_st;
      moving_up   <= (cur_st == MOVE_UP);
      moving_down <= (cur_st == MOVE_DN);
      door_open   <= (cur_st == DOOR);
    end
  end

  assign req = req_q;

endmodule

// File: tb/tb_elevator_req_ctrl.sv
// tb_elevator_req_ctrl: table-driven check of elevator_req_ctrl with
// TRAVEL_CYCLES = 8 and DOOR_CYCLES = 4. Each table row drives the inputs for
// one or more cycles and pushes the expected outputs to a scoreboard queue,
// which is popped and compared just after each clock edge. Hand-written
// sequences cover a cross-floor call made with the door open and, when
// DOOR_HOLD_EN is defined, the door-hold extension.

module tb_elevator_req_ctrl;

  localparam int TRAVEL = 8;
  localparam int DOORC  = 4;

  logic       clk;
  logic       rst;
  logic       up, down, to_one, to_two;
  logic       floor, moving_up, moving_down, door_open;
  logic [3:0] req;
  logic [1:0] state;
`ifdef DOOR_HOLD_EN
  logic       door_hold;
`endif

  elevator_req_ctrl #(
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOORC),
    .TIMER_W      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef DOOR_HOLD_EN
    .door_hold  (door_hold),
`endif
    .up         (up),
    .down       (down),
    .to_one     (to_one),
    .to_two     (to_two),
    .floor      (floor),
    .moving_up  (moving_up),
    .moving_down(moving_down),
    .door_open  (door_open),
    .req        (req),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {state, floor, moving_up, moving_down, door_open, req}.
  typedef logic [9:0] obs_t;

  typedef struct {
    int         n;
    logic       rst;
    logic [3:0] pulse;  // {to_two, to_one, down, up}
    obs_t       exp;
  } vec_t;

  typedef struct {
    obs_t  val;
    obs_t  mask;
    string name;
  } sb_t;

  localparam obs_t M_ALL  = 10'h3FF;
  localparam obs_t M_DOOR = 10'b00_0_0_0_1_0000;
  localparam obs_t M_REQ  = 10'b00_0_0_0_0_1111;
  localparam obs_t M_FD   = 10'b00_1_0_0_1_0000;
  localparam obs_t M_ST   = 10'b11_0_0_0_0_0000;

  vec_t vecs[$];
  sb_t  exp_q[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;

  function automatic obs_t mk(logic [1:0] st, logic fl, logic mu, logic md,
                              logic dr, logic [3:0] rq);
    return {st, fl, mu, md, dr, rq};
  endfunction

  function automatic void add(int n, logic r, logic [3:0] p, logic [1:0] st,
                              logic fl, logic mu, logic md, logic dr, logic [3:0] rq);
    vec_t v;
    v.n     = n;
    v.rst   = r;
    v.pulse = p;
    v.exp   = mk(st, fl, mu, md, dr, rq);
    vecs.push_back(v);
  endfunction

  function automatic obs_t sample();
    return {state, floor, moving_up, moving_down, door_open, req};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_push(input obs_t val, input obs_t mask, input string name);
    sb_t e;
    e.val  = val;
    e.mask = mask;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop_check();
    sb_t  e;
    obs_t a;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      a = sample();
      check(e.name, 32'(a & e.mask), 32'(e.val & e.mask));
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] p);
    rst    = r;
    up     = p[0];
    down   = p[1];
    to_one = p[2];
    to_two = p[3];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the masked outputs equal val or the budget runs out; the
  // scoreboard comparison then records whether the condition was reached.
  task automatic wait_for(input obs_t val, input obs_t mask, input int budget,
                          input string name);
    for (int i = 0; i < budget; i++) begin
      if ((sample() & mask) == (val & mask)) break;
      step();
    end
    sb_push(val, mask, name);
    sb_pop_check();
  endtask

  // The car goes floor 2 -> floor 1 on a to_one call.
  function automatic void add_trip_down();
    add(1, 0, 4'b0100, 0, 1, 0, 0, 0, 4'b0100);
    add(1, 0, 4'b0000, 0, 1, 0, 0, 0, 4'b0100);
    add(7, 0, 4'b0000, 3, 1, 0, 1, 0, 4'b0100);
    add(1, 0, 4'b0000, 3, 1, 0, 1, 0, 4'b0000);
    add(4, 0, 4'b0000, 1, 0, 0, 0, 1, 4'b0000);
    add(2, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int door_cnt;
    drive(1'b1, 4'b0000);
`ifdef DOOR_HOLD_EN
    door_hold = 1'b0;
`endif

    // Reset, then idle.
    add(1,  1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    add(20, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    // up while idle on floor 1: door open 4 cycles, floor unchanged.
    add(1, 0, 4'b0001, 0, 0, 0, 0, 0, 4'b0001);
    add(1, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    add(4, 0, 4'b0000, 1, 0, 0, 0, 1, 4'b0000);
    add(3, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    // to_two from floor 1: 8 cycles moving up, door on floor 2, back to idle.
    add(1, 0, 4'b1000, 0, 0, 0, 0, 0, 4'b1000);
    add(1, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b1000);
    add(7, 0, 4'b0000, 2, 0, 1, 0, 0, 4'b1000);
    add(1, 0, 4'b0000, 2, 0, 1, 0, 0, 4'b0000);
    add(4, 0, 4'b0000, 1, 1, 0, 0, 1, 4'b0000);
    add(2, 0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000);
    // Floor 2, door open: down two cycles into DOOR re-opens (6 cycles), never latched.
    add(1, 0, 4'b1000, 0, 1, 0, 0, 0, 4'b1000);
    add(1, 0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000);
    add(1, 0, 4'b0000, 1, 1, 0, 0, 1, 4'b0000);
    add(1, 0, 4'b0010, 1, 1, 0, 0, 1, 4'b0000);
    add(4, 0, 4'b0000, 1, 1, 0, 0, 1, 4'b0000);
    add(2, 0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000);
    add_trip_down();
    // up and to_two together on floor 1: door first, one idle cycle, then the trip.
    add(1, 0, 4'b1001, 0, 0, 0, 0, 0, 4'b1001);
    add(1, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b1000);
    add(4, 0, 4'b0000, 1, 0, 0, 0, 1, 4'b1000);
    add(1, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b1000);
    add(7, 0, 4'b0000, 2, 0, 1, 0, 0, 4'b1000);
    add(1, 0, 4'b0000, 2, 0, 1, 0, 0, 4'b0000);
    add(4, 0, 4'b0000, 1, 1, 0, 0, 1, 4'b0000);
    add(2, 0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000);
    add_trip_down();
    // Reset during MOVE_UP, with a floor-1 call latched on the way.
    add(1, 0, 4'b1000, 0, 0, 0, 0, 0, 4'b1000);
    add(1, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b1000);
    add(1, 0, 4'b0000, 2, 0, 1, 0, 0, 4'b1000);
    add(1, 0, 4'b0100, 2, 0, 1, 0, 0, 4'b1100);
    add(1, 0, 4'b0000, 2, 0, 1, 0, 0, 4'b1100);
    add(1, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    add(5, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    // Reset with the door open.
    add(1, 0, 4'b0001, 0, 0, 0, 0, 0, 4'b0001);
    add(1, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    add(1, 0, 4'b0000, 1, 0, 0, 0, 1, 4'b0000);
    add(1, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    add(5, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].n; r++) begin
        drive(vecs[i].rst, vecs[i].pulse);
        sb_push(vecs[i].exp, M_ALL, $sformatf("vec%0d_cyc%0d", i, r));
        step();
        sb_pop_check();
      end
    end
    drive(1'b0, 4'b0000);
    step();

    // A floor-2 hall call made while the door is open on floor 1 latches and is served next.
    drive(1'b0, 4'b0001);
    step();
    drive(1'b0, 4'b0000);
    wait_for(mk(0, 0, 0, 0, 1, 0), M_DOOR, 6, "door_opens_floor1");
    drive(1'b0, 4'b0010);
    step();
    drive(1'b0, 4'b0000);
    sb_push(mk(0, 0, 0, 0, 0, 4'b0010), M_REQ, "down_latched_in_door");
    sb_pop_check();
    wait_for(mk(0, 1, 0, 0, 1, 0), M_FD, 30, "arrive_floor2_door");
    sb_push(mk(0, 0, 0, 0, 0, 4'b0000), M_REQ, "down_served");
    sb_pop_check();
    wait_for(mk(0, 0, 0, 0, 0, 0), M_ST | M_DOOR, 20, "idle_floor2");

`ifdef DOOR_HOLD_EN
    // door_hold for 10 cycles in DOOR stretches the 4-cycle door to 14.
    drive(1'b0, 4'b0010);
    step();
    drive(1'b0, 4'b0000);
    door_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      door_hold = (k >= 1 && k < 11);
      step();
      if (door_open) door_cnt++;
    end
    door_hold = 1'b0;
    check("door_hold_open_cycles", 32'(door_cnt), 32'd14);
`else
    // A floor-2 call while idle there opens the door for exactly 4 cycles.
    drive(1'b0, 4'b0010);
    step();
    drive(1'b0, 4'b0000);
    door_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (door_open) door_cnt++;
    end
    check("door_open_cycles_floor2", 32'(door_cnt), 32'(DOORC));
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
